// File: rtl/power_domain_responder_if.sv
// ----------------------------------------------------------------------------
// power_domain_responder_if
// Bundle of power-sequencing signals between the power manager and the
// domain-side responder.
//   master : power manager side (drives sequencing, observes domain status)
//   slave  : domain responder side (observes sequencing, returns status)
// Sequencing : clk_enable, isolation_enable (active low),
//              state_retention_enable (save pulse),
//              state_retention_restore (active-low restore pulse),
//              power_switch_enable (1 = switch open), error_clear
// Status     : domain_state[2:0], power_good, saved_valid, restored,
//              domain_clk_en, protocol_error, error_code[2:0]
// ----------------------------------------------------------------------------
interface power_domain_responder_if;
    logic       clk_enable;
    logic       isolation_enable;
    logic       state_retention_enable;
    logic       state_retention_restore;
    logic       power_switch_enable;
    logic       error_clear;
    logic [2:0] domain_state;
    logic       power_good;
    logic       saved_valid;
    logic       restored;
    logic       domain_clk_en;
    logic       protocol_error;
    logic [2:0] error_code;

    modport master (
        output clk_enable, isolation_enable, state_retention_enable,
               state_retention_restore, power_switch_enable, error_clear,
        input  domain_state, power_good, saved_valid, restored,
               domain_clk_en, protocol_error, error_code
    );

    modport slave (
        input  clk_enable, isolation_enable, state_retention_enable,
               state_retention_restore, power_switch_enable, error_clear,
        output domain_state, power_good, saved_valid, restored,
               domain_clk_en, protocol_error, error_code
    );
endinterface

// File: rtl/power_domain_responder.sv
// ----------------------------------------------------------------------------
// power_domain_responder
// Domain-side end of the power-sequencing interface. Edge-detects the
// manager's sequencing signals, tracks the switchable domain's state
// (ON, CLK_GATED, ISOLATED, SAVED, RAMP_DOWN, OFF, RAMP_UP), models the
// switch ramp delays and flags out-of-order sequencing as a sticky error.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-high reset
//   pd    : sequencing/status bundle (slave modport)
// ----------------------------------------------------------------------------
module power_domain_responder #(
    parameter int RAMP_DOWN_CYCLES = 4,
    parameter int RAMP_UP_CYCLES   = 6,
    parameter int CNT_W            = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    power_domain_responder_if.slave   pd
);

    localparam logic [2:0] ST_ON        = 3'd0;
    localparam logic [2:0] ST_CLK_GATED = 3'd1;
    localparam logic [2:0] ST_ISOLATED  = 3'd2;
    localparam logic [2:0] ST_SAVED     = 3'd3;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd4;
    localparam logic [2:0] ST_OFF       = 3'd5;
    localparam logic [2:0] ST_RAMP_UP   = 3'd6;

    localparam logic [CNT_W-1:0] DOWN_LAST = CNT_W'(RAMP_DOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] UP_LAST   = CNT_W'(RAMP_UP_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pg_q, pg_d;
    logic             sv_q, sv_d;
    logic             rstd_q, rstd_d;
    logic             err_q, err_d;
    logic [2:0]       code_q, code_d;

    // Previous-cycle copies of the sequencing inputs for edge detection.
    logic ce_q, iso_q, save_q, rest_q, sw_q;

    logic ev_clk_off, ev_clk_on, ev_iso_on, ev_iso_off;
    logic ev_save, ev_restore, ev_sw_off, ev_sw_on;
    logic [7:0] evs;
    logic       ev_any, ev_multi;
    logic [2:0] ev_code;
    logic       bad;
    logic [2:0] bad_code;

    assign ev_clk_off = ce_q & ~pd.clk_enable;
    assign ev_clk_on  = ~ce_q & pd.clk_enable;
    assign ev_iso_on  = iso_q & ~pd.isolation_enable;
    assign ev_iso_off = ~iso_q & pd.isolation_enable;
    assign ev_save    = ~save_q & pd.state_retention_enable;
    assign ev_restore = rest_q & ~pd.state_retention_restore;
    assign ev_sw_off  = ~sw_q & pd.power_switch_enable;
    assign ev_sw_on   = sw_q & ~pd.power_switch_enable;

    assign evs      = {ev_clk_off, ev_clk_on, ev_iso_on, ev_iso_off,
                       ev_save, ev_restore, ev_sw_off, ev_sw_on};
    assign ev_any   = |evs;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign ev_multi = |(evs & (evs - 8'd1));

    // Code for a single out-of-place event outside ON (lowest applicable).
    assign ev_code = ev_save                 ? 3'd2 :
                     ev_restore              ? 3'd3 :
                     (ev_sw_off | ev_sw_on)  ? 3'd4 :
                     (ev_iso_on | ev_iso_off)? 3'd5 : 3'd6;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pg_d     = pg_q;
        sv_d     = sv_q;
        rstd_d   = 1'b0;
        err_d    = err_q;
        code_d   = code_q;
        bad      = 1'b0;
        bad_code = 3'd0;

        if (ev_multi) begin
            bad      = 1'b1;
            bad_code = 3'd7;
        end else begin
            case (state_q)
                ST_ON: begin
                    if (ev_clk_off) begin
                        state_d = ST_CLK_GATED;
                    end else if (ev_iso_on | ev_save | ev_restore | ev_sw_off | ev_sw_on) begin
                        bad      = 1'b1;
                        bad_code = 3'd1;
                    end else if (ev_iso_off) begin
                        bad      = 1'b1;
                        bad_code = 3'd5;
                    end
                    // clk_on while already ON is harmless and ignored.
                end
                ST_CLK_GATED: begin
                    if (ev_iso_on)      state_d = ST_ISOLATED;
                    else if (ev_clk_on) state_d = ST_ON;
                    else if (ev_any)    begin bad = 1'b1; bad_code = ev_code; end
                end
                ST_ISOLATED: begin
                    if (ev_save) begin
                        state_d = ST_SAVED;
                        sv_d    = 1'b1;
                    end else if (ev_iso_off) begin
                        state_d = ST_CLK_GATED;
                    end else if (ev_any) begin
                        bad = 1'b1; bad_code = ev_code;
                    end
                end
                ST_SAVED: begin
                    if (ev_sw_off) begin
                        state_d = ST_RAMP_DOWN;
                        pg_d    = 1'b0;
                        cnt_d   = '0;
                    end else if (ev_restore && sv_q) begin
                        state_d = ST_ISOLATED;
                        rstd_d  = 1'b1;
                        sv_d    = 1'b0;
                    end else if (ev_any) begin
                        bad = 1'b1; bad_code = ev_code;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (ev_sw_on) begin
                        state_d = ST_RAMP_UP;
                        cnt_d   = '0;
                    end else begin
                        // The physical ramp keeps going even if a stray
                        // event is flagged this cycle.
                        if (ev_any) begin bad = 1'b1; bad_code = ev_code; end
                        if (cnt_q == DOWN_LAST) begin
                            state_d = ST_OFF;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_OFF: begin
                    if (ev_sw_on) begin
                        state_d = ST_RAMP_UP;
                        cnt_d   = '0;
                    end else if (ev_any) begin
                        bad = 1'b1; bad_code = ev_code;
                    end
                end
                ST_RAMP_UP: begin
                    if (ev_sw_off) begin
                        state_d = ST_RAMP_DOWN;
                        cnt_d   = '0;
                    end else begin
                        if (ev_any) begin bad = 1'b1; bad_code = ev_code; end
                        if (cnt_q == UP_LAST) begin
                            state_d = ST_SAVED;
                            pg_d    = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_ON;
                    pg_d    = 1'b1;
                    cnt_d   = '0;
                end
            endcase
        end

        // A new error beats a simultaneous clear and refreshes the code.
        if (bad) begin
            err_d = 1'b1;
            if (!err_q || pd.error_clear) code_d = bad_code;
        end else if (pd.error_clear) begin
            err_d  = 1'b0;
            code_d = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ON;
            cnt_q   <= '0;
            pg_q    <= 1'b1;
            sv_q    <= 1'b0;
            rstd_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 3'd0;
            ce_q    <= 1'b1;
            iso_q   <= 1'b1;
            save_q  <= 1'b0;
            rest_q  <= 1'b1;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pg_q    <= pg_d;
            sv_q    <= sv_d;
            rstd_q  <= rstd_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ce_q    <= pd.clk_enable;
            iso_q   <= pd.isolation_enable;
            save_q  <= pd.state_retention_enable;
            rest_q  <= pd.state_retention_restore;
            sw_q    <= pd.power_switch_enable;
        end
    end

    assign pd.domain_state   = state_q;
    assign pd.power_good     = pg_q;
    assign pd.saved_valid    = sv_q;
    assign pd.restored       = rstd_q;
    assign pd.domain_clk_en  = ce_q & pg_q;
    assign pd.protocol_error = err_q;
    assign pd.error_code     = code_q;

endmodule

// File: tb/tb_power_domain_responder.sv
module tb_power_domain_responder;

    logic clk = 1'b0;
    logic reset;

    power_domain_responder_if pif();

    power_domain_responder #(
        .RAMP_DOWN_CYCLES(4),
        .RAMP_UP_CYCLES(6),
        .CNT_W(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pd   (pif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       ce, iso, sv, rs, sw, clr;
        int         n;
        logic [2:0] st;
        logic       pg, svd, rstd, dce, err;
        logic [2:0] code;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] exp_q[$];
    int          total  = 0;
    int          passed = 0;

    function automatic void add(string name, logic ce, logic iso, logic sv,
                                logic rs, logic sw, logic clr, int n,
                                logic [2:0] st, logic pg, logic svd,
                                logic rstd, logic dce, logic err,
                                logic [2:0] code);
        vec_t v;
        v.name = name; v.ce = ce; v.iso = iso; v.sv = sv; v.rs = rs;
        v.sw = sw; v.clr = clr; v.n = n; v.st = st; v.pg = pg;
        v.svd = svd; v.rstd = rstd; v.dce = dce; v.err = err; v.code = code;
        vecs.push_back(v);
    endfunction

    function automatic logic [10:0] outs();
        return {pif.domain_state, pif.power_good, pif.saved_valid,
                pif.restored, pif.domain_clk_en, pif.protocol_error,
                pif.error_code};
    endfunction

    task automatic check(string name, logic [10:0] got, logic [10:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got st=%0d pg=%b sv=%b rst=%b dce=%b err=%b code=%0d, expected st=%0d pg=%b sv=%b rst=%b dce=%b err=%b code=%0d",
                      name, got[10:8], got[7], got[6], got[5], got[4], got[3], got[2:0],
                      exp[10:8], exp[7], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
    endtask

    task automatic drive(logic ce, logic iso, logic sv, logic rs, logic sw, logic clr);
        pif.clk_enable              = ce;
        pif.isolation_enable        = iso;
        pif.state_retention_enable  = sv;
        pif.state_retention_restore = rs;
        pif.power_switch_enable     = sw;
        pif.error_clear             = clr;
    endtask

    task automatic run_vec(vec_t v);
        drive(v.ce, v.iso, v.sv, v.rs, v.sw, v.clr);
        exp_q.push_back({v.st, v.pg, v.svd, v.rstd, v.dce, v.err, v.code});
        repeat (v.n) @(posedge clk);
        #1;
        check(v.name, outs(), exp_q.pop_front());
    endtask

    task automatic run_all();
        foreach (vecs[i]) run_vec(vecs[i]);
        vecs.delete();
    endtask

    task automatic do_reset();
        drive(1, 1, 0, 1, 0, 0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 1, 0, 1, 0, 0);
        reset = 1'b1;
        #2;
        check("reset_state", outs(), {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full power-down / power-up sequence, events four cycles apart.
        //   name           ce iso sv rs sw clr n   st pg svd rst dce err code
        add("clk_off",      0, 1, 0, 1, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0);
        add("gated_hold",   0, 1, 0, 1, 0, 0, 3,  1, 1, 0, 0, 0, 0, 0);
        add("iso_on",       0, 0, 0, 1, 0, 0, 1,  2, 1, 0, 0, 0, 0, 0);
        add("iso_hold",     0, 0, 0, 1, 0, 0, 3,  2, 1, 0, 0, 0, 0, 0);
        add("save",         0, 0, 1, 1, 0, 0, 1,  3, 1, 1, 0, 0, 0, 0);
        add("saved_hold",   0, 0, 0, 1, 0, 0, 3,  3, 1, 1, 0, 0, 0, 0);
        add("sw_off",       0, 0, 0, 1, 1, 0, 1,  4, 0, 1, 0, 0, 0, 0);
        add("ramp_dn",      0, 0, 0, 1, 1, 0, 3,  4, 0, 1, 0, 0, 0, 0);
        add("off",          0, 0, 0, 1, 1, 0, 1,  5, 0, 1, 0, 0, 0, 0);
        add("off_hold",     0, 0, 0, 1, 1, 0, 3,  5, 0, 1, 0, 0, 0, 0);
        add("sw_on",        0, 0, 0, 1, 0, 0, 1,  6, 0, 1, 0, 0, 0, 0);
        add("ramp_up",      0, 0, 0, 1, 0, 0, 5,  6, 0, 1, 0, 0, 0, 0);
        add("up_done",      0, 0, 0, 1, 0, 0, 1,  3, 1, 1, 0, 0, 0, 0);
        add("saved_hold2",  0, 0, 0, 1, 0, 0, 3,  3, 1, 1, 0, 0, 0, 0);
        add("restore",      0, 0, 0, 0, 0, 0, 1,  2, 1, 0, 1, 0, 0, 0);
        add("restore_rel",  0, 0, 0, 1, 0, 0, 1,  2, 1, 0, 0, 0, 0, 0);
        add("iso_hold2",    0, 0, 0, 1, 0, 0, 2,  2, 1, 0, 0, 0, 0, 0);
        add("iso_off",      0, 1, 0, 1, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0);
        add("gated_hold2",  0, 1, 0, 1, 0, 0, 3,  1, 1, 0, 0, 0, 0, 0);
        add("clk_on",       1, 1, 0, 1, 0, 0, 1,  0, 1, 0, 0, 1, 0, 0);
        run_all();

        // Abort a ramp-down two cycles in.
        do_reset();
        add("ab_clk_off",   0, 1, 0, 1, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0);
        add("ab_iso_on",    0, 0, 0, 1, 0, 0, 1,  2, 1, 0, 0, 0, 0, 0);
        add("ab_save",      0, 0, 1, 1, 0, 0, 1,  3, 1, 1, 0, 0, 0, 0);
        add("ab_sw_off",    0, 0, 0, 1, 1, 0, 1,  4, 0, 1, 0, 0, 0, 0);
        add("ab_ramp",      0, 0, 0, 1, 1, 0, 1,  4, 0, 1, 0, 0, 0, 0);
        add("ab_sw_on",     0, 0, 0, 1, 0, 0, 1,  6, 0, 1, 0, 0, 0, 0);
        add("ab_ramp_up",   0, 0, 0, 1, 0, 0, 5,  6, 0, 1, 0, 0, 0, 0);
        add("ab_up_done",   0, 0, 0, 1, 0, 0, 1,  3, 1, 1, 0, 0, 0, 0);
        run_all();

        // Illegal ordering, clear collisions, simultaneous events.
        do_reset();
        add("save_in_on",   1, 1, 1, 1, 0, 0, 1,  0, 1, 0, 0, 1, 1, 1);
        add("save_rel",     1, 1, 0, 1, 0, 0, 1,  0, 1, 0, 0, 1, 1, 1);
        add("err_clk_off",  0, 1, 0, 1, 0, 0, 1,  1, 1, 0, 0, 0, 1, 1);
        add("rs_in_gated",  0, 1, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 1, 1);
        add("rs_rel",       0, 1, 0, 1, 0, 0, 1,  1, 1, 0, 0, 0, 1, 1);
        add("clr_with_rs",  0, 1, 0, 0, 0, 1, 1,  1, 1, 0, 0, 0, 1, 3);
        add("rs_rel2",      0, 1, 0, 1, 0, 0, 1,  1, 1, 0, 0, 0, 1, 3);
        add("err_clk_on",   1, 1, 0, 1, 0, 0, 1,  0, 1, 0, 0, 1, 1, 3);
        add("clr_with_sv",  1, 1, 1, 1, 0, 1, 1,  0, 1, 0, 0, 1, 1, 1);
        add("clean_clear",  1, 1, 0, 1, 0, 1, 1,  0, 1, 0, 0, 1, 0, 0);
        add("idle_on",      1, 1, 0, 1, 0, 0, 1,  0, 1, 0, 0, 1, 0, 0);
        add("sim_clk_off",  0, 1, 0, 1, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0);
        add("simultaneous", 1, 0, 0, 1, 0, 0, 1,  1, 1, 0, 0, 1, 1, 7);
        run_all();

        // Reach OFF, then reset asynchronously between clock edges.
        do_reset();
        add("rо_clk_off",   0, 1, 0, 1, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0);
        add("ro_iso_on",    0, 0, 0, 1, 0, 0, 1,  2, 1, 0, 0, 0, 0, 0);
        add("ro_save",      0, 0, 1, 1, 0, 0, 1,  3, 1, 1, 0, 0, 0, 0);
        add("ro_sw_off",    0, 0, 0, 1, 1, 0, 1,  4, 0, 1, 0, 0, 0, 0);
        add("ro_off",       0, 0, 0, 1, 1, 0, 4,  5, 0, 1, 0, 0, 0, 0);
        run_all();

        #2;
        reset = 1'b1;
        #1;
        check("async_reset", outs(), {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
        drive(1, 1, 0, 1, 0, 0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle", outs(), {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
        add("post_clk_off", 0, 1, 0, 1, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0);
        run_all();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
